output_layer: RTL and testbench

- Output stage of the drowsiness-detector MLP. Sits directly downstream of the hidden layer.
- Consumes the hidden layer's N_IN activations and computes N_OUT output neurons with one time-shared multiply-accumulate unit.
- Emits the saturated output scores plus an argmax class index (e.g. alert / drowsy / asleep) to the decision logic.
- Weights and biases live in a local register file, written through a WE port.

---
 rtl/nn_pkg.sv | 33 +++
 rtl/nn_mac.sv | 43 ++++
 rtl/output_layer.sv | 138 +++++++++++++
 tb/tb_output_layer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Types, sizes and the output saturation helper shared by the MLP layers.
// OUTPUT_LAYER_SAT_EN selects clamping in sat_fn; otherwise results wrap to W bits.
package nn_pkg;

  localparam int W     = 10;
  localparam int FRAC  = 6;
  localparam int N_IN  = 5;
  localparam int N_OUT = 3;

  typedef logic signed [W-1:0]   data_t;
  typedef logic signed [2*W+2:0] acc_t;

  typedef enum logic [1:0] {IDLE, MAC, FIN, DONE} state_t;

`ifdef OUTPUT_LAYER_SAT_EN
  localparam acc_t SAT_MAX = acc_t'((1 << (W-1)) - 1);
  localparam acc_t SAT_MIN = -acc_t'(1 << (W-1));
`endif

  function automatic data_t sat_fn(input acc_t r);
`ifdef OUTPUT_LAYER_SAT_EN
    if (r > SAT_MAX) begin
      return data_t'(SAT_MAX);
    end else if (r < SAT_MIN) begin
      return data_t'(SAT_MIN);
    end
    return data_t'(r);
`else
    return data_t'(r[W-1:0]);
`endif
  endfunction

endpackage

// File: rtl/nn_mac.sv
// Time-shared multiply-accumulate with clear, plus the bias-add / floor / saturate
// result path. b carries a weight while accumulating and the bias during FIN.
module nn_mac
  import nn_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  en,
  input  logic  clr,
  input  data_t a,
  input  data_t b,
  output data_t res
);

  acc_t                    acc_q, acc_d;
  logic signed [2*W-1:0]   prod;
  acc_t                    biased;

  always_comb begin
    prod  = a * b;
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + acc_t'(prod);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Bias is aligned to the product scale before the floor shift back to Q3.6.
  always_comb begin
    biased = (acc_q + (acc_t'(b) <<< FRAC)) >>> FRAC;
    res    = sat_fn(biased);
  end

endmodule

// File: rtl/output_layer.sv
// Output stage of the drowsiness MLP: N_OUT neurons on one shared MAC plus argmax.
// Saturating outputs when OUTPUT_LAYER_SAT_EN is defined, wrap-around otherwise.
module output_layer
  import nn_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic [4:0]         w_addr,
  input  logic signed [W-1:0] w_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [W-1:0] in_val [N_IN],
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [W-1:0] out_val [N_OUT],
  output logic [1:0]         out_class
);

  localparam int N_W = N_OUT * (N_IN + 1);

  state_t     state_q, state_d;
  logic [1:0] o_q, o_d;
  logic [2:0] i_q, i_d;
  data_t      in_buf_q [N_IN];
  data_t      in_buf_d [N_IN];
  data_t      w_q [N_W];
  data_t      w_d [N_W];
  data_t      out_val_q [N_OUT];
  data_t      out_val_d [N_OUT];
  logic [1:0] class_q, class_d;
  data_t      max_q, max_d;

  logic       mac_en, mac_clr;
  logic [4:0] w_idx;
  data_t      mac_a, mac_b, mac_res;

  // i_q parks at N_IN during FIN so the same index addresses the bias slot.
  assign w_idx = 5'(o_q) * 5'(N_IN + 1) + 5'(i_q);
  assign mac_a = (i_q < 3'(N_IN)) ? in_buf_q[i_q] : '0;
  assign mac_b = w_q[w_idx];

  nn_mac u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (mac_en),
    .clr   (mac_clr),
    .a     (mac_a),
    .b     (mac_b),
    .res   (mac_res)
  );

  always_comb begin
    state_d   = state_q;
    o_d       = o_q;
    i_d       = i_q;
    in_buf_d  = in_buf_q;
    w_d       = w_q;
    out_val_d = out_val_q;
    class_d   = class_q;
    max_d     = max_q;
    mac_en    = 1'b0;
    mac_clr   = 1'b0;
    case (state_q)
      IDLE: begin
        if (we && (w_addr < 5'(N_W))) begin
          w_d[w_addr] = w_data;
        end
        if (in_valid) begin
          in_buf_d = in_val;
          o_d      = '0;
          i_d      = '0;
          mac_clr  = 1'b1;
          state_d  = MAC;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        if (i_q == 3'(N_IN - 1)) begin
          i_d     = 3'(N_IN);
          state_d = FIN;
        end else begin
          i_d = i_q + 3'd1;
        end
      end
      FIN: begin
        out_val_d[o_q] = mac_res;
        // Strict compare keeps the lower index on ties.
        if ((o_q == 2'd0) || (mac_res > max_q)) begin
          max_d   = mac_res;
          class_d = o_q;
        end
        mac_clr = 1'b1;
        i_d     = '0;
        if (o_q == 2'(N_OUT - 1)) begin
          state_d = DONE;
        end else begin
          o_d     = o_q + 2'd1;
          state_d = MAC;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      o_q     <= '0;
      i_q     <= '0;
      class_q <= '0;
      max_q   <= '0;
      for (int k = 0; k < N_IN; k++) in_buf_q[k] <= '0;
      for (int k = 0; k < N_W; k++) w_q[k] <= '0;
      for (int k = 0; k < N_OUT; k++) out_val_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      o_q       <= o_d;
      i_q       <= i_d;
      class_q   <= class_d;
      max_q     <= max_d;
      in_buf_q  <= in_buf_d;
      w_q       <= w_d;
      out_val_q <= out_val_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_val   = out_val_q;
  assign out_class = class_q;

endmodule

// File: tb/tb_output_layer.sv
// Randomised self-checking bench for output_layer against an arithmetic model.
// Honours OUTPUT_LAYER_SAT_EN the same way the design does.
module tb_output_layer;
  import nn_pkg::*;

  logic                clk;
  logic                rst_n;
  logic                we;
  logic [4:0]          w_addr;
  logic signed [W-1:0] w_data;
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] din [N_IN];
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] dout [N_OUT];
  logic [1:0]          out_class;

  output_layer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (we),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_val    (din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_val   (dout),
    .out_class (out_class)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int n_txn   = 0;

  int mw [18];
  int mx [N_IN];
  int exp_v [N_OUT];
  int exp_cls;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int s10(input int u);
    return (u > 511) ? u - 1024 : u;
  endfunction

  function automatic void mwrite(input int a, input int d);
    if (a < 18) mw[a] = d;
  endfunction

  // Reference: dot product, bias scaled by 2^FRAC, floor divide, clamp or wrap, argmax.
  task automatic compute_expected();
    int acc, r, best;
    for (int o = 0; o < N_OUT; o++) begin
      acc = mw[o*6+5] * 64;
      for (int i = 0; i < N_IN; i++) acc += mx[i] * mw[o*6+i];
      r = acc >>> 6;
`ifdef OUTPUT_LAYER_SAT_EN
      if (r > 511) r = 511;
      if (r < -512) r = -512;
`else
      r = s10(r & 1023);
`endif
      exp_v[o] = r;
    end
    best = 0;
    for (int o = 1; o < N_OUT; o++) if (exp_v[o] > exp_v[best]) best = o;
    exp_cls = best;
  endtask

  task automatic wr(input int a, input int d);
    @(negedge clk);
    we = 1'b1; w_addr = 5'(a); w_data = 10'(d);
    mwrite(a, d);
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic clear_all();
    for (int a = 0; a < 18; a++) wr(a, 0);
  endtask

  // One inference: optional same-cycle write, latency, results, backpressure, release.
  task automatic run_vec(input int hold, input int sim_addr, input int sim_data, input bit bp_write);
    int  k;
    bit  seen;
    @(negedge clk);
    chk("pre_in_ready", int'(in_ready), 1);
    for (int i = 0; i < N_IN; i++) din[i] = 10'(mx[i]);
    if (sim_addr >= 0) begin
      we = 1'b1; w_addr = 5'(sim_addr); w_data = 10'(sim_data);
      mwrite(sim_addr, sim_data);
    end
    compute_expected();
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    we = 1'b0;
    seen = 1'b0;
    k = 0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if (out_valid) seen = 1'b1;
    end
    chk("latency", k, 19);
    for (int o = 0; o < N_OUT; o++) chk($sformatf("out_val%0d", o), int'(dout[o]), exp_v[o]);
    chk("out_class", int'(out_class), exp_cls);
    for (int h = 0; h < hold; h++) begin
      if (bp_write && h == 3) begin
        we = 1'b1; w_addr = 5'd0; w_data = 10'd123;
      end
      @(negedge clk);
      we = 1'b0;
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_in_ready", int'(in_ready), 0);
      for (int o = 0; o < N_OUT; o++) chk($sformatf("hold_val%0d", o), int'(dout[o]), exp_v[o]);
      chk("hold_class", int'(out_class), exp_cls);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("post_valid", int'(out_valid), 0);
    chk("post_in_ready", int'(in_ready), 1);
    n_txn++;
    $display("txn %0d: out=%0d,%0d,%0d class=%0d", n_txn, exp_v[0], exp_v[1], exp_v[2], exp_cls);
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; w_addr = '0; w_data = '0;
    in_valid = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < N_IN; i++) din[i] = '0;
    for (int a = 0; a < 18; a++) mw[a] = 0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    for (int o = 0; o < N_OUT; o++) chk($sformatf("rst_val%0d", o), int'(dout[o]), 0);
    chk("rst_class", int'(out_class), 0);
    rst_n = 1'b1;

    // All-zero weights
    for (int i = 0; i < N_IN; i++) mx[i] = 1;
    run_vec(0, -1, 0, 1'b0);

    // Identity-like weights
    for (int o = 0; o < N_OUT; o++) wr(o*6 + o, 64);
    mx[0] = 64; mx[1] = 128; mx[2] = 192; mx[3] = 0; mx[4] = 0;
    run_vec(0, -1, 0, 1'b0);
    chk("ident_val2", int'(dout[2]), 192);
    chk("ident_class", int'(out_class), 2);

    // Saturation / wrap with all weights at 511
    for (int o = 0; o < N_OUT; o++) for (int i = 0; i < N_IN; i++) wr(o*6 + i, 511);
    for (int i = 0; i < N_IN; i++) mx[i] = 511;
    run_vec(2, -1, 0, 1'b0);

    // Tie between neurons 1 and 2
    clear_all();
    wr(0, 50); wr(6, 100); wr(12, 100);
    mx[0] = 64; mx[1] = 0; mx[2] = 0; mx[3] = 0; mx[4] = 0;
    run_vec(0, -1, 0, 1'b0);
    chk("tie_class", int'(out_class), 1);

    // Negative bias with zero weights, and backpressure with an ignored write
    clear_all();
    wr(5, -64);
    for (int i = 0; i < N_IN; i++) mx[i] = s10($urandom_range(0, 1023));
    run_vec(10, -1, 0, 1'b1);
    chk("negbias_val0", int'(dout[0]), -64);

    // Same-cycle write and capture: the new weight must be used
    mx[0] = 64; mx[1] = 0; mx[2] = 0; mx[3] = 0; mx[4] = 0;
    run_vec(0, 1, 77, 1'b0);
    run_vec(0, -1, 0, 1'b0);

    // Randomised weights, inputs, out-of-range writes and backpressure
    for (int t = 0; t < 8; t++) begin
      int nw;
      nw = $urandom_range(4, 12);
      for (int j = 0; j < nw; j++) wr($urandom_range(0, 31), s10($urandom_range(0, 1023)));
      for (int i = 0; i < N_IN; i++) mx[i] = s10($urandom_range(0, 1023));
      if (t == 5) run_vec($urandom_range(0, 3), $urandom_range(0, 17), s10($urandom_range(0, 1023)), 1'b0);
      else        run_vec($urandom_range(0, 3), -1, 0, 1'b0);
    end

    // Reset during MAC aborts and clears weights
    for (int i = 0; i < N_IN; i++) din[i] = 10'(s10($urandom_range(0, 1023)));
    @(negedge clk);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", int'(out_valid), 0);
    chk("abort_in_ready", int'(in_ready), 1);
    for (int o = 0; o < N_OUT; o++) chk($sformatf("abort_val%0d", o), int'(dout[o]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < 18; a++) mw[a] = 0;
    for (int i = 0; i < N_IN; i++) mx[i] = s10($urandom_range(0, 1023));
    run_vec(0, -1, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
